tx_frame_sched: RTL and testbench

Transmit sequencer between the Tx FIFO and the O-QPSK modulator of the Zigbee PHY. On a start command it emits the PPDU header (preamble, SFD, PHR) itself, then pops payload bytes from the Tx FIFO through its read enable and forwards them on a valid/ready byte stream to the modulator. It reports completion, FIFO underrun and bad lengths to the APB/control side.

---
 rtl/tx_ctrl_pkg.sv | 25 ++
 rtl/tx_frame_sched.sv | 160 ++++++++++++++++
 tb/tb_tx_frame_sched.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_ctrl_pkg.sv
// Shared types and constants for the Zigbee PHY transmit sequencer.
package tx_ctrl_pkg;

    localparam int unsigned PHR_LEN_W        = 7;
    localparam logic [7:0]  SFD_DEFAULT      = 8'hA7;
    localparam int unsigned PHY_MAX_LEN      = 127;
    localparam int unsigned PREAMBLE_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_PHR,
        ST_FETCH,
        ST_WAIT_DATA,
        ST_SEND,
        ST_DONE
    } tx_state_t;

    // A PSDU length is usable when it is non-zero and within the configured maximum.
    function automatic logic len_ok(input logic [PHR_LEN_W-1:0] len, input int unsigned max_len);
        return (len != '0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/tx_frame_sched.sv
// Transmit sequencer: emits preamble/SFD/PHR, then streams payload bytes from the Tx FIFO
// to the O-QPSK modulator over a valid/ready byte interface.
module tx_frame_sched
    import tx_ctrl_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = PREAMBLE_DEFAULT,
    parameter logic [7:0]  SFD_VAL      = SFD_DEFAULT,
    parameter int unsigned MAX_LEN      = PHY_MAX_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [PHR_LEN_W-1:0] frame_len,
    input  logic                 abort,
    input  logic                 fifo_empty,
    input  logic [7:0]           fifo_data,
    output logic                 fifo_rd_en,
    output logic [7:0]           mod_data,
    output logic                 mod_valid,
    input  logic                 mod_ready,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 tx_err
);

    localparam logic [PHR_LEN_W-1:0] PRE_LAST = PHR_LEN_W'(PREAMBLE_LEN - 1);

    tx_state_t            state, state_n;
    logic [PHR_LEN_W-1:0] len, len_n;
    logic [PHR_LEN_W-1:0] cnt, cnt_n;
    logic [PHR_LEN_W-1:0] cnt_inc;
    logic [7:0]           mod_data_n;
    logic                 mod_valid_n;
    logic                 busy_n;
    logic                 tx_done_n;
    logic                 tx_err_n;
    logic                 accept;

    assign accept  = mod_valid && mod_ready;
    assign cnt_inc = cnt + PHR_LEN_W'(1);

    // Pop is a decode of FETCH so the read data is present during WAIT_DATA.
    assign fifo_rd_en = (state == ST_FETCH) && !fifo_empty && !abort;

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            len       <= '0;
            cnt       <= '0;
            mod_data  <= 8'h00;
            mod_valid <= 1'b0;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
        end else begin
            state     <= state_n;
            len       <= len_n;
            cnt       <= cnt_n;
            mod_data  <= mod_data_n;
            mod_valid <= mod_valid_n;
            busy      <= busy_n;
            tx_done   <= tx_done_n;
            tx_err    <= tx_err_n;
        end
    end

    // Next-state and next-output logic; the byte on the stream only moves on acceptance.
    always_comb begin
        state_n     = state;
        len_n       = len;
        cnt_n       = cnt;
        mod_data_n  = mod_data;
        mod_valid_n = mod_valid;
        tx_done_n   = 1'b0;
        tx_err_n    = 1'b0;

        if (abort) begin
            state_n     = ST_IDLE;
            mod_valid_n = 1'b0;
            mod_data_n  = 8'h00;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (tx_start) begin
                        if (len_ok(frame_len, MAX_LEN)) begin
                            state_n     = ST_PREAMBLE;
                            len_n       = frame_len;
                            cnt_n       = '0;
                            mod_valid_n = 1'b1;
                            mod_data_n  = 8'h00;
                        end else begin
                            tx_err_n = 1'b1;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (accept) begin
                        if (cnt == PRE_LAST) begin
                            state_n    = ST_SFD;
                            cnt_n      = '0;
                            mod_data_n = SFD_VAL;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                ST_SFD: begin
                    if (accept) begin
                        state_n    = ST_PHR;
                        mod_data_n = {1'b0, len};
                    end
                end
                ST_PHR: begin
                    if (accept) begin
                        state_n     = ST_FETCH;
                        cnt_n       = '0;
                        mod_valid_n = 1'b0;
                        mod_data_n  = 8'h00;
                    end
                end
                ST_FETCH: begin
                    if (fifo_empty) begin
                        state_n  = ST_IDLE;
                        tx_err_n = 1'b1;
                    end else begin
                        state_n = ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    state_n     = ST_SEND;
                    mod_data_n  = fifo_data;
                    mod_valid_n = 1'b1;
                end
                ST_SEND: begin
                    if (accept) begin
                        cnt_n       = cnt_inc;
                        mod_valid_n = 1'b0;
                        mod_data_n  = 8'h00;
                        if (cnt_inc == len) begin
                            state_n   = ST_DONE;
                            tx_done_n = 1'b1;
                        end else begin
                            state_n = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Scoreboard bench for tx_frame_sched: stimulus queues expected stream bytes, a negedge monitor checks them.
module tb_tx_frame_sched;
    import tx_ctrl_pkg::*;

    localparam int unsigned TB_MAX_LEN = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start = 1'b0;
    logic [6:0] frame_len = 7'd0;
    logic       abort = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic [7:0] mod_data;
    logic       mod_valid;
    logic       mod_ready = 1'b1;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    tx_frame_sched #(
        .PREAMBLE_LEN (4),
        .SFD_VAL      (8'hA7),
        .MAX_LEN      (TB_MAX_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_start   (tx_start),
        .frame_len  (frame_len),
        .abort      (abort),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .mod_data   (mod_data),
        .mod_valid  (mod_valid),
        .mod_ready  (mod_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         pop_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] pl_q[$];
    logic       pop_req = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         rdy_mode = 0;
    logic [31:0] cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Modulator ready pattern: 0 = always ready, 1 = ready one cycle in four, 2 = stalled.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       mod_ready = 1'b1;
            1:       mod_ready = (cyc[1:0] == 2'd0);
            default: mod_ready = 1'b0;
        endcase
        cyc = cyc + 1;
    end

    // FIFO model: read data appears the cycle after a pop request.
    always @(posedge clk) begin
        if (pop_req && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Monitor: scoreboard on each accepted byte, hold-stability, pulse counting.
    always @(negedge clk) begin
        pop_req = fifo_rd_en;
        if (!reset) begin
            if (prev_hold && !abort)
                chk("hold_stable", {23'd0, mod_valid, mod_data}, {23'd0, 1'b1, prev_data});
            if (mod_valid && mod_ready && !abort) begin
                if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, mod_data}, 32'hFFFF_FFFF);
                else chk("stream_byte", {24'd0, mod_data}, {24'd0, exp_q.pop_front()});
            end
            if (fifo_rd_en) begin
                pop_cnt++;
                chk("pop_nonempty", {31'd0, fifo_q.size() != 0}, 32'd1);
            end
            if (tx_done) done_cnt++;
            if (tx_err) err_cnt++;
        end
        prev_hold = mod_valid && !mod_ready && !abort && !reset;
        prev_data = mod_data;
    end

    task automatic push_header(input logic [6:0] len, input bit with_phr);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'hA7);
        if (with_phr) exp_q.push_back({1'b0, len});
    endtask

    task automatic chk_idle_zero(input string name);
        chk(name, {19'd0, mod_valid, fifo_rd_en, busy, tx_done, tx_err, mod_data}, 32'd0);
    endtask

    // Full frame with pl_q loaded into the FIFO and expected on the stream.
    task automatic run_frame(input logic [6:0] len, input int exp_done, input int exp_err);
        int d0, e0, p0, n, np;
        d0 = done_cnt; e0 = err_cnt; p0 = pop_cnt; np = pl_q.size();
        push_header(len, 1'b1);
        foreach (pl_q[i]) begin
            fifo_q.push_back(pl_q[i]);
            exp_q.push_back(pl_q[i]);
        end
        tick();
        frame_len = len;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        chk("busy_rise", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        chk("frame_timeout", {31'd0, n < 3000}, 32'd1);
        tick();
        chk("done_count", done_cnt - d0, exp_done);
        chk("err_count", err_cnt - e0, exp_err);
        chk("pop_count", pop_cnt - p0, np);
        chk("stream_drained", exp_q.size(), 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
        exp_q.delete();
    endtask

    task automatic bad_len(input logic [6:0] len);
        int e0;
        e0 = err_cnt;
        frame_len = len;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        chk("badlen_err", {29'd0, tx_err, busy, mod_valid}, 32'b100);
        tick();
        chk("badlen_pulse", {29'd0, tx_err, busy, mod_valid}, 32'd0);
        chk("badlen_count", err_cnt - e0, 32'd1);
    endtask

    initial begin
        int d0, e0, p0;
        repeat (3) tick();
        chk_idle_zero("reset_state");
        reset = 1'b0;
        tick();

        pl_q = {8'h11, 8'h22, 8'h33};
        run_frame(7'd3, 1, 0);

        rdy_mode = 1;
        pl_q = {8'h11, 8'h22, 8'h33};
        run_frame(7'd3, 1, 0);
        rdy_mode = 0;

        pl_q = {8'h44, 8'h55};
        run_frame(7'd4, 0, 1);

        pl_q.delete();
        for (int i = 0; i < 100; i++) pl_q.push_back(8'(i + 1));
        run_frame(7'd100, 1, 0);

        bad_len(7'd0);
        bad_len(7'd127);
        bad_len(7'd101);

        // Abort while the PHR byte is stalled.
        d0 = done_cnt; e0 = err_cnt;
        push_header(7'd2, 1'b0);
        frame_len = 7'd2;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        repeat (5) tick();
        rdy_mode = 2;
        repeat (3) tick();
        chk("phr_waiting", {23'd0, mod_valid, mod_data}, {23'd0, 1'b1, 8'h02});
        abort = 1'b1;
        tick();
        chk_idle_zero("abort_phr");
        abort = 1'b0;
        rdy_mode = 0;
        tick();
        chk("abort_phr_drained", exp_q.size(), 32'd0);
        chk("abort_phr_no_pulse", (done_cnt - d0) + (err_cnt - e0), 32'd0);

        // Abort in WAIT_DATA discards the popped byte.
        d0 = done_cnt; e0 = err_cnt; p0 = pop_cnt;
        fifo_q.push_back(8'h5A);
        fifo_q.push_back(8'h6B);
        push_header(7'd2, 1'b1);
        tick();
        frame_len = 7'd2;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        repeat (7) tick();
        chk("wait_data_state", {30'd0, mod_valid, busy}, 32'b01);
        abort = 1'b1;
        tick();
        chk_idle_zero("abort_wait");
        abort = 1'b0;
        tick();
        chk("abort_wait_pops", pop_cnt - p0, 32'd1);
        chk("abort_wait_drained", exp_q.size(), 32'd0);
        chk("abort_wait_no_pulse", (done_cnt - d0) + (err_cnt - e0), 32'd0);
        fifo_q.delete();
        tick();

        pl_q = {8'hC1, 8'hC2, 8'hC3};
        run_frame(7'd3, 1, 0);

        // Reset asserted while a payload byte is offered.
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        push_header(7'd3, 1'b1);
        tick();
        frame_len = 7'd3;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        repeat (8) tick();
        chk("send_state", {23'd0, mod_valid, mod_data}, {23'd0, 1'b1, 8'h11});
        reset = 1'b1;
        #1;
        chk_idle_zero("async_reset");
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("post_reset_busy", {31'd0, busy}, 32'd0);
        chk("post_reset_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        fifo_q.delete();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
